// File: rtl/ram128_fifo.sv
// FIFO of up to 129 words: 128 words in external 128xWIDTH distributed RAM
// plus one registered output word, with read priority over writes.
module ram128_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       LEVEL,
  output logic             RAM_WE,
  output logic [6:0]       RAM_A,
  output logic [WIDTH-1:0] RAM_D,
  input  logic [WIDTH-1:0] RAM_O
);

  logic [6:0]       wr_ptr_q, wr_ptr_d;
  logic [6:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]       ram_count_q, ram_count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       level_q, level_d;

  logic out_free;
  logic rd_sel;
  logic in_ready;
  logic push;
  logic bypass;
  logic ram_we;
  logic ram_empty;
  logic ram_full;

  always_comb begin
    ram_empty = (ram_count_q == 8'd0);
    ram_full  = (ram_count_q == 8'd128);
    out_free  = !out_valid_q || OUT_READY;
    rd_sel    = RST_N && !ram_empty && out_free;
    in_ready  = RST_N && !rd_sel && !ram_full;
    push      = IN_VALID && in_ready;
    bypass    = push && ram_empty && out_free;
    ram_we    = push && !bypass;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    // ram_we and rd_sel are mutually exclusive, so one count update at most
    if (ram_we) begin
      wr_ptr_d    = wr_ptr_q + 7'd1;
      ram_count_d = ram_count_q + 8'd1;
    end
    if (rd_sel) begin
      rd_ptr_d    = rd_ptr_q + 7'd1;
      ram_count_d = ram_count_q - 8'd1;
      out_data_d  = RAM_O;
      out_valid_d = 1'b1;
    end else if (bypass) begin
      out_data_d  = IN_DATA;
      out_valid_d = 1'b1;
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
    level_d = ram_count_d + {7'd0, out_valid_d};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign LEVEL     = level_q;
  assign RAM_WE    = ram_we;
  assign RAM_A     = rd_sel ? rd_ptr_q : wr_ptr_q;
  assign RAM_D     = IN_DATA;

endmodule

// File: tb/tb_ram128_fifo.sv
// Directed and random checks of ram128_fifo against an external RAM
// model and a queue scoreboard.
module tb_ram128_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] level;
  logic       ram_we;
  logic [6:0] ram_a;
  logic [7:0] ram_d;
  logic [7:0] ram_o;

  logic [7:0] mem [128];

  int n_chk  = 0;
  int n_fail = 0;
  int clash  = 0;
  bit saw_w127, saw_r127;

  always #5 clk = ~clk;

  ram128_fifo #(.WIDTH(8)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .LEVEL(level),
    .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_D(ram_d), .RAM_O(ram_o)
  );

  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_d;
  assign ram_o = mem[ram_a];

  always @(negedge clk) begin
    if (ram_we && dut.rd_sel) clash++;
    if (ram_we && ram_a == 7'd127) saw_w127 = 1'b1;
    if (dut.rd_sel && ram_a == 7'd127) saw_r127 = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_w;
    int pushed;
    int cyc;
    int bval;

    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    tick(); tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);

    // single push bypasses RAM
    rst_n = 1'b1; in_data = 8'h5A; in_valid = 1'b1;
    #1;
    chk("byp_in_ready", 32'(in_ready), 1);
    chk("byp_ram_we", 32'(ram_we), 0);
    tick();
    in_valid = 1'b0;
    chk("byp_out_valid", 32'(out_valid), 1);
    chk("byp_out_data", 32'(out_data), 32'h5A);
    chk("byp_level", 32'(level), 1);
    tick();
    chk("hold_out_data", 32'(out_data), 32'h5A);
    chk("hold_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("pop_out_valid", 32'(out_valid), 0);
    chk("pop_level", 32'(level), 0);
    chk("pop_out_data", 32'(out_data), 32'h5A);

    // fill to 129
    out_ready = 1'b0;
    for (int i = 0; i <= 128; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      #1;
      chk("fill_in_ready", 32'(in_ready), 1);
      chk("fill_ram_we", 32'(ram_we), (i == 0) ? 0 : 1);
      if (i > 0) chk("fill_ram_a", 32'(ram_a), i - 1);
      tick();
    end
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_level", 32'(level), 129);
    chk("full_out_data", 32'(out_data), 0);

    // drain; full with OUT_READY=1 still refuses pushes
    out_ready = 1'b1; in_valid = 1'b1;
    #1;
    chk("full_rd_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    for (int k = 0; k <= 128; k++) begin
      chk("drain_out_valid", 32'(out_valid), 1);
      chk("drain_out_data", 32'(out_data), k);
      chk("drain_level", 32'(level), 129 - k);
      tick();
    end
    chk("drained_out_valid", 32'(out_valid), 0);
    chk("drained_level", 32'(level), 0);

    // ram_count=3 with output held, then drain while pushing
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hA0 + 8'(i); in_valid = 1'b1;
      tick();
    end
    chk("prio_level", 32'(level), 4);
    out_ready = 1'b1; in_data = 8'hB0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("prio_in_ready", 32'(in_ready), 0);
      chk("prio_out_data", 32'(out_data), 32'hA0 + c);
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("stream_in_ready", 32'(in_ready), 1);
      tick();
      chk("stream_out_data", 32'(out_data), 32'hB0 + j);
      chk("stream_level", 32'(level), 1);
      in_data = in_data + 8'd1;
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid), 0);

    // random traffic, 300 words through a queue scoreboard
    saw_w127 = 1'b0; saw_r127 = 1'b0;
    pushed = 0; cyc = 0;
    while ((pushed < 300 || q.size() != 0) && cyc < 5000) begin
      in_valid  = (pushed < 300) && ($urandom_range(0, 7) != 0);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = (cyc < 250) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_level", 32'(level), q.size());
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 32'(out_valid), 0);
        end else begin
          exp_w = q.pop_front();
          chk("rnd_order", 32'(out_data), 32'(exp_w));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        pushed++;
      end
      tick();
      cyc++;
    end
    chk("rnd_done_in_time", 32'(cyc < 5000), 1);
    chk("rnd_wr_wrap", 32'(saw_w127), 1);
    chk("rnd_rd_wrap", 32'(saw_r127), 1);
    chk("rnd_no_clash", 32'(clash), 0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("rnd_final_valid", 32'(out_valid), 0);

    // reset mid-operation at level 50
    for (int i = 0; i < 50; i++) begin
      in_data = 8'(i + 3); in_valid = 1'b1;
      tick();
    end
    chk("pre_rst_level", 32'(level), 50);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_ram_we", 32'(ram_we), 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_out_valid", 32'(out_valid), 0);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    bval = 32'hC3;
    in_data = 8'hC3; in_valid = 1'b1;
    #1;
    chk("post_rst_bypass_we", 32'(ram_we), 0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_out_valid1", 32'(out_valid), 1);
    chk("post_rst_out_data", 32'(out_data), bval);
    chk("post_rst_level1", 32'(level), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
